// File: rtl/impulse_sequencer_pkg.sv
// impulse_sequencer_pkg: shared state encoding, default widths and type-field bit positions.
package impulse_seq_pkg;
  localparam int FW_DEF = 48;
  localparam int TW_DEF = 64;
  localparam int CW_DEF = 32;
  localparam int TYPE_CHIRP_BIT = 0;
  localparam int TYPE_REPEAT_BIT = 7;
  typedef enum logic [2:0] {IDLE, ARMED, PULSE, GAP, DONE} state_t;
endpackage

// File: rtl/impulse_sequencer_chirp_accum.sv
// chirp_accum: DDS frequency register with a tick-gated rate counter for linear chirp steps.
module chirp_accum
  import impulse_seq_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clk_en,
  input  logic          i_load,
  input  logic          i_run,
  input  logic [FW-1:0] i_freq,
  input  logic [FW-1:0] i_step,
  input  logic [CW-1:0] i_rate,
  output logic [FW-1:0] o_dds_freq,
  output logic          o_dds_wr
);
  logic [FW-1:0] r_freq;
  logic [CW-1:0] r_rcnt;
  logic          r_wr;
  logic          w_adv;
  always_comb w_adv = i_run && i_clk_en;
  // a step fires on the tick where the countdown reaches one, then the count reloads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_freq <= '0;
      r_rcnt <= '0;
      r_wr   <= 1'b0;
    end else if (i_load) begin
      r_freq <= i_freq;
      r_rcnt <= i_rate;
      r_wr   <= 1'b1;
    end else if (w_adv && r_rcnt <= CW'(1)) begin
      r_freq <= r_freq + i_step;
      r_rcnt <= i_rate;
      r_wr   <= 1'b1;
    end else begin
      r_wr <= 1'b0;
      if (w_adv) r_rcnt <= r_rcnt - 1'b1;
    end
  assign o_dds_freq = r_freq;
  assign o_dds_wr   = r_wr;
endmodule

// File: rtl/impulse_sequencer.sv
// impulse_sequencer: latches a burst descriptor on a write strobe and plays out gated pulses with blanking and chirp.
// Define IMPULSE_REPEAT_EN to let type bit 7 loop the burst until the next write.
module impulse_sequencer
  import impulse_seq_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int TW = TW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clk_en,
  input  logic [TW-1:0] i_sys_time,
  input  logic          i_spi_wr,
  input  logic [FW-1:0] i_freq,
  input  logic [FW-1:0] i_freq_step,
  input  logic [CW-1:0] i_freq_rate,
  input  logic [TW-1:0] i_time_start,
  input  logic [15:0]   i_n_impulse,
  input  logic [7:0]    i_type_impulse,
  input  logic [CW-1:0] i_interval_ti,
  input  logic [CW-1:0] i_interval_tp,
  input  logic [CW-1:0] i_tblank1,
  input  logic [CW-1:0] i_tblank2,
  output logic          o_tx_gate,
  output logic          o_blank,
  output logic [FW-1:0] o_dds_freq,
  output logic          o_dds_wr,
  output logic          o_busy,
  output logic [15:0]   o_imp_cnt,
  output logic          o_done,
  output logic          o_err_late
);
  state_t        r_state;
  logic          r_wr_d, r_first, r_tx, r_done, r_err;
  logic [FW-1:0] r_freq, r_step;
  logic [CW-1:0] r_rate, r_ti, r_tp, r_tb1, r_tb2;
  logic [TW-1:0] r_ts;
  logic [15:0]   r_n, r_imp;
  logic [7:0]    r_type;
  logic [CW-1:0] r_wcnt, r_pcnt, r_b1, r_b2;
  logic          w_wr_evt, w_go, w_gap_end, w_done_end, w_rep, w_enter, w_run;
  logic [CW-1:0] w_width, w_period;
  logic          w_unused;
  always_comb begin
    w_wr_evt   = i_spi_wr && !r_wr_d;
    w_go       = r_ts == '0 || i_sys_time == r_ts;
    w_width    = r_ti == '0 ? CW'(1) : r_ti;
    w_period   = r_tp > w_width ? r_tp : w_width;
    w_gap_end  = i_clk_en && r_state == GAP && r_pcnt <= CW'(1);
    w_done_end = i_clk_en && r_state == DONE && r_b2 <= CW'(1);
`ifdef IMPULSE_REPEAT_EN
    w_rep      = r_type[TYPE_REPEAT_BIT] && r_n != '0;
`else
    w_rep      = 1'b0;
`endif
    w_enter    = !w_wr_evt && ((r_state == ARMED && w_go && r_n != '0) ||
                               (w_gap_end && r_imp < r_n) || (w_done_end && w_rep));
    w_run      = !w_wr_evt && r_state == PULSE && r_type[TYPE_CHIRP_BIT] && r_rate != '0;
    w_unused   = ^{r_type[6:1], r_type[TYPE_REPEAT_BIT]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_wr_d  <= 1'b0;
      r_first <= 1'b0;
      r_tx    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_freq  <= '0;
      r_step  <= '0;
      r_rate  <= '0;
      r_ti    <= '0;
      r_tp    <= '0;
      r_tb1   <= '0;
      r_tb2   <= '0;
      r_ts    <= '0;
      r_n     <= '0;
      r_type  <= '0;
      r_imp   <= '0;
      r_wcnt  <= '0;
      r_pcnt  <= '0;
      r_b1    <= '0;
      r_b2    <= '0;
    end else begin
      r_wr_d <= i_spi_wr;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (i_clk_en && r_b1 != '0) r_b1 <= r_b1 - 1'b1;
      if (w_wr_evt) begin
        r_freq  <= i_freq;
        r_step  <= i_freq_step;
        r_rate  <= i_freq_rate;
        r_ti    <= i_interval_ti;
        r_tp    <= i_interval_tp;
        r_tb1   <= i_tblank1;
        r_tb2   <= i_tblank2;
        r_ts    <= i_time_start;
        r_n     <= i_n_impulse;
        r_type  <= i_type_impulse;
        r_state <= ARMED;
        r_first <= 1'b1;
        r_tx    <= 1'b0;
        r_b1    <= '0;
        r_b2    <= '0;
        r_imp   <= '0;
      end else if (w_enter) begin
        r_state <= PULSE;
        r_tx    <= 1'b1;
        r_imp   <= r_state == DONE ? 16'd1 : r_imp + 1'b1;
        r_b1    <= r_tb1;
        r_wcnt  <= w_width;
        r_pcnt  <= w_period;
      end else begin
        case (r_state)
          // a start match here only remains for an empty burst
          ARMED:
            if (w_go) begin
              r_state <= DONE;
              r_b2    <= r_tb2;
            end else if (r_first && i_sys_time > r_ts) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else r_first <= 1'b0;
          PULSE:
            if (i_clk_en) begin
              r_pcnt <= r_pcnt - 1'b1;
              if (r_wcnt <= CW'(1)) begin
                r_tx    <= 1'b0;
                r_state <= GAP;
              end else r_wcnt <= r_wcnt - 1'b1;
            end
          GAP:
            if (w_gap_end) begin
              r_state <= DONE;
              r_b2    <= r_tb2;
            end else if (i_clk_en) r_pcnt <= r_pcnt - 1'b1;
          DONE:
            if (w_done_end) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else if (i_clk_en) r_b2 <= r_b2 - 1'b1;
          default: ;
        endcase
      end
    end
  chirp_accum #(.FW(FW), .CW(CW)) u_chirp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clk_en   (i_clk_en),
    .i_load     (w_enter),
    .i_run      (w_run),
    .i_freq     (r_freq),
    .i_step     (r_step),
    .i_rate     (r_rate),
    .o_dds_freq (o_dds_freq),
    .o_dds_wr   (o_dds_wr)
  );
  assign o_tx_gate  = r_tx;
  assign o_blank    = r_b1 != '0 || (r_state == DONE && r_b2 != '0);
  assign o_busy     = r_state != IDLE;
  assign o_imp_cnt  = r_imp;
  assign o_done     = r_done;
  assign o_err_late = r_err;
endmodule

// File: doc/impulse_sequencer.md
Name: impulse_sequencer

Overview:
- Downstream consumer of the SPI parameter-receive stage.
- On each parameter-write strobe it latches the burst descriptor: start time, pulse count and type, Ti, Tp, blanking, and frequency/chirp.
- It waits for system time to reach the start time, then generates the burst:
  - transmit gate,
  - blanking gate,
  - per-cycle DDS frequency word with optional linear chirp.
- It sits between the SPI receiver and the DDS/transmit-control logic.

Parameters:
- FW, 48, frequency word width (freq, freq_step, dds_freq)
- TW, 64, system-time width
- CW, 32, interval counter width (Ti, Tp, blank, rate)

Ports:
- clk in 1: system clock
- rst_n in 1: asynchronous active-low reset
- clk_en in 1: tick enable; all interval, rate and blank counters advance only when high
- sys_time in TW: current system time, one count per clk_en tick
- spi_wr in 1: parameter-write strobe, rising edge significant
- freq in FW: start frequency word
- freq_step in FW: chirp increment (two's complement)
- freq_rate in CW: ticks between chirp steps
- time_start in TW: burst start time
- n_impulse in 16: number of pulses
- type_impulse in 8: bit0 = 1 chirp / 0 fixed; bit7 = repeat (see Optional Feature)
- interval_ti in CW: pulse width, ticks
- interval_tp in CW: pulse period, ticks
- tblank1 in CW: blanking length from each pulse start
- tblank2 in CW: post-burst blanking length
- tx_gate out 1: transmit gate
- blank out 1: receiver blanking
- dds_freq out FW: current frequency word
- dds_wr out 1: one-cycle strobe, dds_freq updated
- busy out 1: not IDLE
- imp_cnt out 16: pulses started in current burst
- done out 1: one-cycle end-of-burst strobe
- err_late out 1: one-cycle strobe, start time already passed

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; shadow registers 0.
- Write detect:
  - spi_wr registered once; rising edge = wr_evt.
  - On wr_evt in any state, all inputs are copied to shadow registers and the state becomes ARMED next cycle.
  - A burst in progress is aborted: tx_gate/blank drop on that same edge, no done.
- ARMED:
  - If time_start_r == 0 or sys_time == time_start_r, go to PULSE.
  - If sys_time > time_start_r on the first ARMED cycle: err_late pulse, go to IDLE.
- n_impulse_r == 0: ARMED -> DONE directly, no pulses.
- PULSE:
  - On entry: imp_cnt += 1; dds_freq <= freq_r; dds_wr = 1; tx_gate = 1; blank counter loaded with tblank1_r; period counter loaded with max(tp_r, ti_r, 1).
  - tx_gate stays high for max(ti_r, 1) ticks, then state goes to GAP.
- Chirp (bit0 = 1 and rate_r != 0), active in PULSE only:
  - Every rate_r ticks: dds_freq += step_r, modulo 2^FW (wraps silently); dds_wr pulse on each step.
  - Fixed mode or rate_r == 0: no steps.
- GAP:
  - tx_gate = 0; wait until the period counter expires.
  - Then: if imp_cnt < n_impulse_r, go to PULSE (re-arm frequency); else go to DONE.
  - When tp_r <= ti_r, GAP lasts 0 ticks: the next pulse starts on the tick after the pulse ends.
- blank:
  - High while the tblank1 counter is nonzero, or in DONE while the tblank2 counter is nonzero.
  - The tblank1 counter reloads at each pulse start, even if still running.
- DONE:
  - Loads tblank2_r; counts it down.
  - At zero: done pulse; imp_cnt holds its value; state goes to IDLE.
- Timing:
  - Outputs are registered; tx_gate rises exactly 1 clk after the start-match cycle.
  - With clk_en=0, state and counters freeze; sys_time matching is still evaluated.

Optional Feature:
- Macro: IMPULSE_REPEAT_EN
- Defined: if type_impulse_r[7] = 1, DONE goes back to PULSE instead of IDLE, with imp_cnt cleared and no done strobe; repeats until the next wr_evt.
- Not defined: bit7 ignored; one burst per write.

Decomposition:
- Package impulse_seq_pkg:
  - state enum: IDLE, ARMED, PULSE, GAP, DONE
  - FW/TW/CW defaults
  - TYPE_CHIRP_BIT = 0, TYPE_REPEAT_BIT = 7
- Sub-module chirp_accum: frequency register plus rate counter; inputs load, run, clk_en, freq, step, rate; outputs dds_freq, dds_wr.

Test Plan:
- Basic burst: write with time_start=100, n=3, ti=4, tp=10, fixed freq=0x123456 -> tx_gate high for ticks 101-104, 111-114, 121-124; dds_freq=0x123456; imp_cnt=3; done after tblank2 ticks.
- Chirp: freq=1000, step=5, rate=2, ti=7 -> dds_freq = 1000, 1005, 1010, 1015 within the pulse, with a dds_wr per change; restarts at 1000 on the next pulse.
- Late start: sys_time=500, time_start=200 -> err_late single pulse, busy=0, tx_gate never rises.
- Edge values:
  - n=0 -> no tx_gate; done after tblank2 ticks.
  - tp=2, ti=5 -> back-to-back pulses of width 5.
  - step=-1 with freq=0 -> dds_freq wraps to 0xFFFF_FFFF_FFFF.
- Abort and reset:
  - New spi_wr mid-pulse -> tx_gate drops next cycle, no done; new burst runs with the new parameters.
  - rst_n low mid-burst -> all outputs 0 immediately.
- Gating and blanking: clk_en toggling 1/0 -> pulse width doubles in clk cycles but stays ti ticks; blank = tblank1 ticks from each pulse start.
